stack_controller: RTL and testbench
===================================

STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 SHALL have parameter SP_BASE, default 16'h0000, meaning empty-stack pointer value and reset value of sp.
REQ-002 SHALL have parameter SP_LIMIT, default 16'h00FF, meaning full-stack pointer value; no push is accepted at this value.
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- push  in  1  push request.
- pop  in  1  pop request.
- load_sp  in  1  load sp from sp_load_val.
- sp_load_val  in  16  new pointer value.
- push_data  in  16  word to push.
- mem_rdata  in  16  memory read data.
- mem_ready  in  1  memory completes the current access this cycle.
- req_ready  out  1  controller idle, so a request is accepted this cycle.
- done  out  1  one-cycle pulse when the operation completes.
- pop_data  out  16  word returned by the last pop.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- sp  out  16  current stack pointer.
- overflow  out  1  one-cycle pulse when a push is refused.
- underflow  out  1  one-cycle pulse when a pop is refused.

Function
REQ-004 SHALL implement FSM states IDLE, WRITE, READ, DONE; req_ready=1 only in IDLE.
REQ-005 SHALL give request priority in IDLE as load_sp > pop > push; lower-priority requests that cycle are dropped.
REQ-006 load_sp in IDLE SHALL set sp=sp_load_val next cycle, pulse done that cycle, and stay in IDLE.
REQ-007 push in IDLE with sp!=SP_LIMIT SHALL enter WRITE: mem_addr=sp, mem_wdata=push_data (captured at acceptance), mem_we=1.
REQ-008 In WRITE, mem_we SHALL stay asserted until mem_ready=1; sp SHALL then increment by 1 on that edge and the FSM SHALL go to DONE.
REQ-009 pop in IDLE with sp!=SP_BASE SHALL decrement sp by 1 on acceptance and enter READ: mem_addr=new sp, mem_re=1.
REQ-010 In READ, mem_re SHALL stay asserted until mem_ready=1; pop_data SHALL capture mem_rdata on that edge and the FSM SHALL go to DONE.
REQ-011 DONE SHALL last exactly one cycle with done=1 and then return to IDLE; minimum latency from acceptance to done is 2 cycles.
REQ-012 mem_we and mem_re SHALL never be asserted together; both SHALL be 0 outside WRITE and READ.
REQ-013 push, pop and load_sp SHALL be ignored outside IDLE.
REQ-014 pop_data SHALL hold its value until the next successful pop.

Reset
REQ-015 reset_n=0 SHALL asynchronously force state=IDLE, sp=SP_BASE, pop_data=0, and mem_we=mem_re=done=overflow=underflow=0; req_ready SHALL then read 1.
REQ-016 Reset during WRITE or READ SHALL abort the access with no sp update, and pop_data SHALL be cleared to 0.

Configuration
REQ-017 With STACK_CTRL_GUARD_EN defined, a push at sp==SP_LIMIT SHALL pulse overflow for one cycle, do no memory access and no sp change, and stay in IDLE; a pop at sp==SP_BASE SHALL pulse underflow in the same way.
REQ-018 Without STACK_CTRL_GUARD_EN, overflow and underflow SHALL be tied to 0, every push and pop SHALL proceed, and sp SHALL wrap modulo 2^16.

Structure
REQ-019 Package stack_ctrl_pkg SHALL hold the FSM state enum and the 16-bit word width constant.
REQ-020 Sub-module sp_reg SHALL hold the pointer register with load, increment and decrement controls (mutually exclusive; load wins); the FSM drives it.

Verification
REQ-021 Push 16'hA5A5 at sp=0 with mem_ready=1 immediately -> mem_we 1 cycle at addr 0, sp=1, done 2 cycles after acceptance.
REQ-022 Pop after REQ-021 with mem_rdata=16'hA5A5 and mem_ready delayed 3 cycles -> mem_re held 3 cycles at addr 0, pop_data=16'hA5A5, sp=0.
REQ-023 Guard enabled, load_sp 16'h00FF then push -> overflow pulse, no mem_we, sp stays 16'h00FF; pop at sp=0 -> underflow pulse.
REQ-024 push, pop and load_sp=16'h0010 asserted together in IDLE -> only the load happens, sp=16'h0010, no memory access.
REQ-025 reset_n deasserted mid-WRITE with mem_ready=0 -> mem_we drops immediately, sp=SP_BASE, req_ready=1.
REQ-026 Guard disabled, sp=16'hFFFF, push -> write at 16'hFFFF and sp wraps to 16'h0000.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared types and constants for the stack controller.
// Contents: FSM state encoding and the data/pointer word width.
// Optional feature macro used by the controller: STACK_CTRL_GUARD_EN.
package stack_ctrl_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sp_reg.sv
// sp_reg: stack pointer register with load / increment / decrement controls.
// Ports: clk, reset_n (async active-low), load + load_val, inc, dec, sp (registered).
// Load wins over inc/dec; the FSM guarantees inc and dec are never raised together.
module sp_reg
  import stack_ctrl_pkg::*;
#(
  parameter logic [WORD_W-1:0] SP_BASE = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_val,
  input  logic              inc,
  input  logic              dec,
  output logic [WORD_W-1:0] sp
);

  logic [WORD_W-1:0] sp_q;
  logic [WORD_W-1:0] sp_d;

  // Arithmetic is plain modulo 2^WORD_W; any range guarding lives in the FSM.
  always_comb begin
    sp_d = sp_q;
    if (load) begin
      sp_d = load_val;
    end else if (inc) begin
      sp_d = sp_q + WORD_W'(1);
    end else if (dec) begin
      sp_d = sp_q - WORD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q <= SP_BASE;
    end else begin
      sp_q <= sp_d;
    end
  end

  assign sp = sp_q;

endmodule

// File: rtl/stack_controller.sv
// stack_controller: push/pop/load front end for a memory-backed stack.
// Ports: request inputs (push, pop, load_sp), memory handshake (mem_* with mem_ready),
//        status (req_ready, done, overflow, underflow), pop_data and sp.
// Optional macro STACK_CTRL_GUARD_EN: refuse push at SP_LIMIT / pop at SP_BASE with a pulse.
module stack_controller
  import stack_ctrl_pkg::*;
#(
  parameter logic [WORD_W-1:0] SP_BASE  = 16'h0000,
  parameter logic [WORD_W-1:0] SP_LIMIT = 16'h00FF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              load_sp,
  input  logic [WORD_W-1:0] sp_load_val,
  input  logic [WORD_W-1:0] push_data,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              req_ready,
  output logic              done,
  output logic [WORD_W-1:0] pop_data,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [WORD_W-1:0] sp,
  output logic              overflow,
  output logic              underflow
);

  state_t            state_q;
  logic [WORD_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic              done_q;
  logic [WORD_W-1:0] pop_data_q;

  logic              idle;
  logic              push_block;
  logic              pop_block;
  logic              sp_load;
  logic              sp_inc;
  logic              sp_dec;

`ifdef STACK_CTRL_GUARD_EN
  logic              ovf_q;
  logic              udf_q;

  assign push_block = (sp == SP_LIMIT);
  assign pop_block  = (sp == SP_BASE);
  assign overflow   = ovf_q;
  assign underflow  = udf_q;
`else
  assign push_block = 1'b0;
  assign pop_block  = 1'b0;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

  assign idle = (state_q == ST_IDLE);

  // Pointer controls follow the request priority load_sp > pop > push.
  // Pop pre-decrements on acceptance so the read address is the new sp;
  // push post-increments only once the write is acknowledged.
  assign sp_load = idle && load_sp;
  assign sp_dec  = idle && !load_sp && pop && !pop_block;
  assign sp_inc  = (state_q == ST_WRITE) && mem_ready;

  sp_reg #(
    .SP_BASE (SP_BASE)
  ) u_sp_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (sp_load),
    .load_val (sp_load_val),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .sp       (sp)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      done_q      <= 1'b0;
      pop_data_q  <= '0;
`ifdef STACK_CTRL_GUARD_EN
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
`endif
    end else begin
      // Status outputs are single-cycle pulses unless re-asserted below.
      done_q <= 1'b0;
`ifdef STACK_CTRL_GUARD_EN
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (load_sp) begin
            done_q <= 1'b1;
          end else if (pop) begin
            if (pop_block) begin
`ifdef STACK_CTRL_GUARD_EN
              udf_q <= 1'b1;
`endif
            end else begin
              mem_addr_q <= sp - WORD_W'(1);
              mem_re_q   <= 1'b1;
              state_q    <= ST_READ;
            end
          end else if (push) begin
            if (push_block) begin
`ifdef STACK_CTRL_GUARD_EN
              ovf_q <= 1'b1;
`endif
            end else begin
              mem_addr_q  <= sp;
              mem_wdata_q <= push_data;
              mem_we_q    <= 1'b1;
              state_q     <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_READ: begin
          if (mem_ready) begin
            mem_re_q   <= 1'b0;
            pop_data_q <= mem_rdata;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          mem_we_q <= 1'b0;
          mem_re_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = idle;
  assign done      = done_q;
  assign pop_data  = pop_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_stack_controller.sv
// tb_stack_controller: randomized bench for stack_controller against a stack model.
// Ports: none (top-level bench); the bench also plays the role of the memory.
// Honours STACK_CTRL_GUARD_EN so the model matches the build under test.
module tb_stack_controller;

  localparam logic [15:0] SP_BASE  = 16'h0000;
  localparam logic [15:0] SP_LIMIT = 16'h00FF;

`ifdef STACK_CTRL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam int K_PUSH = 0;
  localparam int K_POP  = 1;
  localparam int K_LOAD = 2;
  localparam int K_ALL  = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        load_sp = 1'b0;
  logic [15:0] sp_load_val = '0;
  logic [15:0] push_data = '0;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        req_ready;
  logic        done;
  logic [15:0] pop_data;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] sp;
  logic        overflow;
  logic        underflow;

  stack_controller #(
    .SP_BASE  (SP_BASE),
    .SP_LIMIT (SP_LIMIT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (push),
    .pop         (pop),
    .load_sp     (load_sp),
    .sp_load_val (sp_load_val),
    .push_data   (push_data),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .req_ready   (req_ready),
    .done        (done),
    .pop_data    (pop_data),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .sp          (sp),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // bench_mem is the memory the DUT talks to; model_mem is what a correct stack holds.
  logic [15:0] bench_mem [int];
  logic [15:0] model_mem [int];
  logic [15:0] sp_m  = SP_BASE;
  logic [15:0] pop_m = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] bench_rd(input logic [15:0] a);
    return bench_mem.exists(int'(a)) ? bench_mem[int'(a)] : 16'h0000;
  endfunction

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'h0000;
  endfunction

  // One request issued from IDLE; 'cycles' is how many access cycles the memory
  // stalls for (mem_ready rises in the last one). Called and returning at a negedge.
  task automatic do_op(input int kind, input logic [15:0] val, input int cycles);
    logic [15:0] exp_addr;
    logic [15:0] sp_next;
    logic [15:0] pop_next;
    bit          access;
    bit          exp_ovf;
    bit          exp_udf;
    access   = 1'b0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    exp_addr = '0;
    sp_next  = sp_m;
    pop_next = pop_m;
    case (kind)
      K_LOAD, K_ALL: sp_next = val;
      K_PUSH: begin
        if (GUARD && sp_m == SP_LIMIT) exp_ovf = 1'b1;
        else begin
          access = 1'b1;
          exp_addr = sp_m;
          model_mem[int'(sp_m)] = val;
          sp_next = sp_m + 16'd1;
        end
      end
      default: begin
        if (GUARD && sp_m == SP_BASE) exp_udf = 1'b1;
        else begin
          access = 1'b1;
          exp_addr = sp_m - 16'd1;
          pop_next = model_rd(exp_addr);
          sp_next = exp_addr;
        end
      end
    endcase

    check("idle_req_ready", req_ready, 1);
    push        = (kind == K_PUSH) || (kind == K_ALL);
    pop         = (kind == K_POP)  || (kind == K_ALL);
    load_sp     = (kind == K_LOAD) || (kind == K_ALL);
    sp_load_val = val;
    push_data   = val;
    @(negedge clk);
    push = 1'b0; pop = 1'b0; load_sp = 1'b0;
    push_data = ~val;

    if (access) begin
      for (int i = 1; i <= cycles; i++) begin
        check("acc_we", mem_we, kind == K_PUSH);
        check("acc_re", mem_re, kind == K_POP);
        check("acc_addr", mem_addr, exp_addr);
        check("acc_busy", req_ready, 0);
        check("acc_done", done, 0);
        check("acc_pop_hold", pop_data, pop_m);
        if (kind == K_PUSH) check("acc_wdata", mem_wdata, val);
        if (kind == K_POP) check("acc_sp_predec", sp, exp_addr);
        mem_rdata = (i == cycles) ? bench_rd(mem_addr) : 16'hDEAD;
        mem_ready = (i == cycles);
        if (i == cycles && mem_we) bench_mem[int'(mem_addr)] = mem_wdata;
        @(negedge clk);
      end
      mem_ready = 1'b0;
      mem_rdata = 16'(($urandom));
      check("done_pulse", done, 1);
      check("done_we", mem_we, 0);
      check("done_re", mem_re, 0);
      check("done_busy", req_ready, 0);
      check("done_sp", sp, sp_next);
      check("done_pop_data", pop_data, pop_next);
      @(negedge clk);
      check("after_done", done, 0);
      check("after_ready", req_ready, 1);
    end else begin
      check("nacc_done", done, (kind == K_LOAD) || (kind == K_ALL));
      check("nacc_ovf", overflow, exp_ovf);
      check("nacc_udf", underflow, exp_udf);
      check("nacc_we", mem_we, 0);
      check("nacc_re", mem_re, 0);
      check("nacc_sp", sp, sp_next);
      check("nacc_pop_data", pop_data, pop_next);
      check("nacc_ready", req_ready, 1);
      @(negedge clk);
      check("nacc_ovf_end", overflow, 0);
      check("nacc_udf_end", underflow, 0);
      check("nacc_done_end", done, 0);
    end
    sp_m  = sp_next;
    pop_m = pop_next;
  endtask

  initial begin
    int kind;
    int pick;
    logic [15:0] val;

    repeat (2) @(negedge clk);
    check("rst_sp", sp, SP_BASE);
    check("rst_ready", req_ready, 1);
    check("rst_we_re", {mem_we, mem_re}, 0);
    check("rst_pulses", {done, overflow, underflow}, 0);
    check("rst_pop_data", pop_data, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Push with immediate ack, then pop with a three-cycle read stall.
    do_op(K_PUSH, 16'hA5A5, 1);
    do_op(K_POP, 16'h0000, 3);
    check("pop_a5a5", pop_data, 16'hA5A5);

    // All three requests at once: only the load takes effect.
    do_op(K_ALL, 16'h0010, 1);

    // Pointer wrap at the top of the address space.
    do_op(K_LOAD, 16'hFFFF, 1);
    do_op(K_PUSH, 16'h1234, 2);
    check("wrap_sp", sp, 16'h0000);

    // Limit / base boundaries (refused with a guard, wrapping without).
    do_op(K_LOAD, SP_LIMIT, 1);
    do_op(K_PUSH, 16'h5A5A, 1);
    do_op(K_LOAD, SP_BASE, 1);
    do_op(K_POP, 16'h0000, 1);

    // Reset in the middle of a stalled write.
    do_op(K_LOAD, 16'h0040, 1);
    push = 1'b1; push_data = 16'h7777;
    @(negedge clk);
    push = 1'b0;
    check("midw_we", mem_we, 1);
    @(negedge clk);
    check("midw_we_held", mem_we, 1);
    reset_n = 1'b0;
    #1;
    check("midw_rst_we", mem_we, 0);
    check("midw_rst_sp", sp, SP_BASE);
    check("midw_rst_ready", req_ready, 1);
    check("midw_rst_pop", pop_data, 0);
    sp_m = SP_BASE;
    pop_m = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_sp", sp, SP_BASE);

    // Randomized traffic, biased toward the pointer boundaries.
    for (int n = 0; n < 250; n++) begin
      pick = $urandom_range(99);
      kind = (pick < 40) ? K_PUSH : (pick < 75) ? K_POP : (pick < 92) ? K_LOAD : K_ALL;
      case ($urandom_range(5))
        0: val = SP_BASE;
        1: val = SP_LIMIT;
        2: val = 16'hFFFF;
        3: val = SP_LIMIT - 16'd1;
        default: val = 16'($urandom);
      endcase
      do_op(kind, val, $urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
